// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex decode table
// and the all-on / all-off patterns. Bit 6 is segment a, bit 0 is segment g.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_ALL_ON  = 7'h7F;
  localparam logic [6:0] SEG_ALL_OFF = 7'h00;

  // 6 keeps its top bar, 9 keeps its bottom bar, b and d are lowercase.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment lookup; every one of the 16 codes is legal.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[d_i];
  end

endmodule

// File: rtl/es4_6_hex7seg.sv
// Registered hex-to-seven-segment digit with lamp test, blanking and
// ripple-blank (leading-zero suppression) for chaining multiple digits.
module es4_6_hex7seg
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  input  logic       lt_n,
  input  logic       bl_n,
  input  logic       rbi_n,
  output logic [6:0] y,
  output logic       rbo_n
);

  localparam logic [6:0] Y_RST = ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;

  logic [6:0] tbl_seg;
  logic [6:0] seg_d;
  logic [6:0] y_d, y_q;
  logic       rbo_d, rbo_q;

  seg7_decode u_dec (
    .d_i   (d),
    .seg_o (tbl_seg)
  );

  // Override priority: lamp test, then blank, then suppressed zero.
  always_comb begin
    seg_d = tbl_seg;
    rbo_d = 1'b1;
    if (!lt_n) begin
      seg_d = SEG_ALL_ON;
    end else if (!bl_n) begin
      seg_d = SEG_ALL_OFF;
    end else if (!rbi_n && d == 4'h0) begin
      seg_d = SEG_ALL_OFF;
      rbo_d = 1'b0;
    end
  end

  // Only the segment drives follow display polarity; rbo_n never inverts.
  assign y_d = ACTIVE_LOW ? ~seg_d : seg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= Y_RST;
      rbo_q <= 1'b1;
    end else begin
      y_q   <= y_d;
      rbo_q <= rbo_d;
    end
  end

  assign y     = y_q;
  assign rbo_n = rbo_q;

endmodule

// File: tb/tb_es4_6_hex7seg.sv
// Bench for es4_6_hex7seg: one instance of each polarity on shared inputs,
// checked one cycle after each edge against a rule-based reference model.
module tb_es4_6_hex7seg;

  logic       clk;
  logic       rst_n;
  logic [3:0] d;
  logic       lt_n, bl_n, rbi_n;
  logic [6:0] y0, y1;
  logic       rbo0, rbo1;

  int compared = 0;
  int mismatched = 0;

  logic [6:0] font [16];

  es4_6_hex7seg #(.ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .d(d), .lt_n(lt_n), .bl_n(bl_n),
    .rbi_n(rbi_n), .y(y0), .rbo_n(rbo0)
  );

  es4_6_hex7seg #(.ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d), .lt_n(lt_n), .bl_n(bl_n),
    .rbi_n(rbi_n), .y(y1), .rbo_n(rbo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {rbo_n, y} for the given inputs and polarity.
  function automatic logic [7:0] model(input logic [3:0] dv, input logic lt,
                                       input logic bl, input logic rbi,
                                       input logic al);
    logic [6:0] s;
    logic       r;
    r = 1'b1;
    if (lt == 1'b0)                  s = 7'h7F;
    else if (bl == 1'b0)             s = 7'h00;
    else if (rbi == 1'b0 && dv == 0) begin s = 7'h00; r = 1'b0; end
    else                             s = font[dv];
    if (al) s = 7'h7F ^ s;
    return {r, s};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed {rbo_n,y}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    chk({tag, "/al0"}, {rbo0, y0}, e0);
    chk({tag, "/al1"}, {rbo1, y1}, e1);
  endtask

  // Apply inputs, clock once, then compare against the model of those inputs.
  task automatic step(input string tag, input logic [3:0] dv, input logic lt,
                      input logic bl, input logic rbi);
    d = dv; lt_n = lt; bl_n = bl; rbi_n = rbi;
    @(posedge clk); #1;
    chk_both(tag, model(dv, lt, bl, rbi, 1'b0), model(dv, lt, bl, rbi, 1'b1));
  endtask

  initial begin
    font = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    rst_n = 1'b1; d = 4'h3; lt_n = 1'b1; bl_n = 1'b1; rbi_n = 1'b1;

    // Let outputs take a non-reset value, then reset between edges.
    @(posedge clk); #1;
    #2 rst_n = 1'b0; #1;
    chk_both("reset_async", 8'h80, 8'hFF);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step($sformatf("sweep_%0h", i), 4'(i), 1'b1, 1'b1, 1'b1);
    chk("sweep_F_direct", {rbo0, y0}, 8'hC7);

    step("lt_over_bl", 4'h3, 1'b0, 1'b0, 1'b1);
    chk("lt_direct", {1'b0, y0}, 8'h7F);
    step("bl_after_lt", 4'h3, 1'b1, 1'b0, 1'b1);
    step("rbi_zero", 4'h0, 1'b1, 1'b1, 1'b0);
    chk("rbi_zero_direct", {rbo0, y0}, 8'h00);
    step("rbi_five", 4'h5, 1'b1, 1'b1, 1'b0);
    step("zero_shown", 4'h0, 1'b1, 1'b1, 1'b1);
    step("bl_rbi_zero", 4'h0, 1'b1, 1'b0, 1'b0);
    step("al_eight", 4'h8, 1'b1, 1'b1, 1'b1);
    chk("al_eight_direct", {rbo1, y1}, 8'h80);
    step("al_one", 4'h1, 1'b1, 1'b1, 1'b1);
    chk("al_one_direct", {rbo1, y1}, 8'hCF);

    // Mid-sweep reset at d=A overrides without an edge.
    step("pre_rst_9", 4'h9, 1'b1, 1'b1, 1'b1);
    step("pre_rst_A", 4'hA, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0; #1;
    chk_both("reset_mid", 8'h80, 8'hFF);
    @(posedge clk); #1;
    chk_both("reset_held", 8'h80, 8'hFF);
    @(negedge clk); rst_n = 1'b1;
    step("post_rst_A", 4'hA, 1'b1, 1'b1, 1'b1);

    // Random stimulus with controls biased toward inactive.
    for (int i = 0; i < 80; i++) begin
      step($sformatf("rand_%0d", i), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/es4_6_hex7seg.md
# es4_6_hex7seg

Registered hexadecimal-to-seven-segment decoder for the 4-bit display path. Converts a nibble `d` (0–F) into segment drives `y` for one common-cathode digit. Adds lamp-test, blanking and ripple-blanking (leading-zero suppression) so several instances can be chained into a multi-digit display. Sits between the value/counter logic and the board's seven-segment pins.

## Interface
- `ACTIVE_LOW`, default 0: when 1, all `y` bits are inverted at the output register to drive common-anode displays.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `d`  input  4  hex digit to display.
- `lt_n`  input  1  lamp test, active-low; forces all segments on.
- `bl_n`  input  1  blank, active-low; forces all segments off.
- `rbi_n`  input  1  ripple-blank in, active-low; suppresses display of digit 0.
- `y`  output  7  segment drives {a,b,c,d,e,f,g}, `y[6]`=a … `y[0]`=g; logical 1 = segment lit (before `ACTIVE_LOW` inversion).
- `rbo_n`  output  1  ripple-blank out, active-low; asserted when this digit was blanked as a suppressed zero.

## Operation
- Decode table for `y` (hex, ACTIVE_LOW=0): 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→70, 8→7F, 9→7B, A→77, b→1F, C→4E, d→3D, E→4F, F→47.
- 6 is shown with the top bar; 9 is shown with the bottom bar; b and d are lowercase.
- Priority, highest first:
  - `lt_n`=0: y=7F and `rbo_n`=1.
  - `bl_n`=0: y=00 and `rbo_n`=1.
  - `rbi_n`=0 and `d`=0: y=00 and `rbo_n`=0.
  - otherwise: table value and `rbo_n`=1.
- The decode is a full case over all 16 codes; no illegal inputs exist.
- `ACTIVE_LOW`=1 inverts `y` only. `rbo_n` keeps its polarity.

## Timing
- `y` and `rbo_n` are registered: inputs sampled on rising `clk` appear on the outputs after that edge, giving 1-cycle latency.
- There are no combinational paths from inputs to outputs.
- Reset (`rst_n`=0): `y` goes to all-off immediately and asynchronously (00, or 7F if ACTIVE_LOW=1), and `rbo_n` goes to 1.
- Reset is released synchronously in effect: the first decode is captured on the first rising edge with `rst_n`=1.
- Reset asserted mid-stream overrides everything at once. No other state exists.
- Input changes every cycle are supported; each output reflects exactly the inputs of the previous edge.
- Chaining: `rbo_n` of digit k feeds `rbi_n` of digit k−1. Each stage adds one cycle.
  - Leading-zero suppression across N digits settles after N cycles of stable input.
  - Chaining is the integrator's responsibility; no internal alignment is provided.

## Structure
- Shared package `seg7_pkg`:
  - segment index constants SEG_A..SEG_G;
  - 16-entry `localparam logic [6:0] HEX_SEG[16]` decode table;
  - constants SEG_ALL_ON=7'h7F and SEG_ALL_OFF=7'h00.
- One combinational sub-module `seg7_decode` (nibble → 7-bit pattern from the table), instantiated once.
- Top level holds:
  - the priority/override logic;
  - the polarity inversion;
  - the output registers.

## Test plan
- Reset with `rst_n`=0 → y=00 and `rbo_n`=1 immediately, without waiting for a clock edge. Repeat with ACTIVE_LOW=1 → y=7F.
- Controls inactive; sweep `d`=0..F, one value per cycle → y follows the table one cycle later: 7E, 30, 6D, 79, 33, 5B, 5F, 70, 7F, 7B, 77, 1F, 4E, 3D, 4F, 47.
- `lt_n`=0 with `d`=3 and `bl_n`=0 → y=7F. Then `lt_n`=1 → y=00.
- `rbi_n`=0, `d`=0 → y=00, `rbo_n`=0. Then `d`=5 → y=5B, `rbo_n`=1.
- `rbi_n`=1, `d`=0 → y=7E, `rbo_n`=1.
- ACTIVE_LOW=1, `d`=8 → y=00. Then `d`=1 → y=4F.
- Assert `rst_n` low mid-sweep at `d`=A → y drops to 00 without waiting for a clock edge. After release, the next edge shows the decode of the current `d`.
